// File: rtl/microc_pkg.sv
// Shared types and constants for the microc control unit: FSM encoding,
// opcode classes and fields, ALU operation codes and the control vector.
package microc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_PAUSE  = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  // Opcode classes live in the top two bits; jumps and HLT are full codes.
  localparam logic [1:0] CLS_LI  = 2'b00;
  localparam logic [1:0] CLS_ALU = 2'b01;

  localparam logic [5:0] OPC_J   = 6'b100000;
  localparam logic [5:0] OPC_JZ  = 6'b100001;
  localparam logic [5:0] OPC_JNZ = 6'b100010;
  localparam logic [5:0] OPC_HLT = 6'b111111;

  localparam logic [2:0] ALU_PASS = 3'b000;

  typedef struct packed {
    logic       pc_we;
    logic       s_inc;
    logic       s_inm;
    logic       we3;
    logic       wez;
    logic [2:0] op;
    logic       halt;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

  function automatic logic [1:0] opc_class(input logic [5:0] opc);
    return opc[5:4];
  endfunction

  function automatic logic [2:0] opc_aluop(input logic [5:0] opc);
    return opc[3:1];
  endfunction

endpackage

// File: rtl/microc_uc_if.sv
// Control bus between the microc datapath and its control unit: opcode and
// zero flag come up from the datapath, enables and ALU op go down to it.
interface microc_uc_if;

  logic [5:0] Opcode;
  logic       z;
  logic       pc_we;
  logic       s_inc;
  logic       s_inm;
  logic       we3;
  logic       wez;
  logic [2:0] Op;

  modport master (
    input  Opcode, z,
    output pc_we, s_inc, s_inm, we3, wez, Op
  );

  modport slave (
    output Opcode, z,
    input  pc_we, s_inc, s_inm, we3, wez, Op
  );

endinterface

// File: rtl/microc_decod.sv
// Purely combinational instruction decoder: latched opcode plus zero flag
// in, full control vector out. Anything not recognised behaves as a NOP.
module microc_decod
  import microc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic       z,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl       = CTRL_NONE;
    ctrl.pc_we = 1'b1;
    ctrl.s_inc = 1'b1;
    ctrl.op    = ALU_PASS;

    if (opc_class(opcode) == CLS_LI) begin
      ctrl.s_inm = 1'b1;
      ctrl.we3   = 1'b1;
    end else if (opc_class(opcode) == CLS_ALU) begin
      ctrl.op  = opc_aluop(opcode);
      ctrl.we3 = 1'b1;
      ctrl.wez = 1'b1;
    end else begin
      // Conditional jumps take the target when the condition holds (s_inc=0).
      case (opcode)
        OPC_J:   ctrl.s_inc = 1'b0;
        OPC_JZ:  ctrl.s_inc = ~z;
        OPC_JNZ: ctrl.s_inc = z;
        OPC_HLT: begin
          ctrl.pc_we = 1'b0;
          ctrl.s_inc = 1'b0;
          ctrl.halt  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/microc_uc.sv
// Multi-cycle control unit for microc: FETCH/DECODE/EXEC sequencing with
// start, halt, single-step and a saturating retired-instruction counter.
module microc_uc
  import microc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             step_mode,
  input  logic             step,
  microc_uc_if.master      bus,
  output logic             halted,
  output logic             busy,
  output logic [CNT_W-1:0] icount
);

  state_t     state, state_nx;
  logic [5:0] opcode_q;
  ctrl_t      dec, ctrl_q;
  logic       exec;

  microc_decod u_decod (
    .opcode (opcode_q),
    .z      (bus.z),
    .ctrl   (dec)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (start) state_nx = ST_FETCH;
      ST_FETCH:  state_nx = ST_DECODE;
      ST_DECODE: state_nx = ST_EXEC;
      ST_EXEC: begin
        if (ctrl_q.halt)    state_nx = ST_HALT;
        else if (step_mode) state_nx = ST_PAUSE;
        else                state_nx = ST_FETCH;
      end
      ST_PAUSE: begin
        if (step)                    state_nx = ST_FETCH;
        else if (!step_mode && !start) state_nx = ST_IDLE;
      end
      ST_HALT:   state_nx = ST_HALT;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 opcode_q <= '0;
    else if (state == ST_FETCH) opcode_q <= bus.Opcode;
  end

  // z is sampled here, one cycle after the previous EXEC wrote it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  ctrl_q <= CTRL_NONE;
    else if (state == ST_DECODE) ctrl_q <= dec;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      icount <= '0;
    else if (state == ST_EXEC && icount != {CNT_W{1'b1}})
      icount <= icount + CNT_W'(1);
  end

  assign exec = (state == ST_EXEC);

  always_comb begin
    bus.pc_we = exec & ctrl_q.pc_we;
    bus.s_inc = exec & ctrl_q.s_inc;
    bus.s_inm = exec & ctrl_q.s_inm;
    bus.we3   = exec & ctrl_q.we3;
    bus.wez   = exec & ctrl_q.wez;
    bus.Op    = exec ? ctrl_q.op : ALU_PASS;
  end

  assign halted = (state == ST_HALT);
  assign busy   = (state == ST_FETCH) || (state == ST_DECODE) ||
                  (state == ST_EXEC)  || (state == ST_PAUSE);

endmodule

// File: tb/tb_microc_uc.sv
// Self-checking bench for microc_uc: expected EXEC control vectors are
// queued when an opcode is presented and popped when its EXEC cycle arrives.
module tb_microc_uc;
  import microc_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        step_mode = 1'b0;
  logic        step = 1'b0;
  logic        sat_start = 1'b0;
  logic        halted, busy, sat_halted, sat_busy;
  logic [15:0] icount;
  logic [3:0]  sat_icount;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  exp_v;
  logic [15:0] exp_icount;

  microc_uc_if bus ();
  microc_uc_if sat_bus ();

  microc_uc #(.CNT_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .step_mode (step_mode),
    .step      (step),
    .bus       (bus.master),
    .halted    (halted),
    .busy      (busy),
    .icount    (icount)
  );

  microc_uc #(.CNT_W(4)) dut_sat (
    .clk       (clk),
    .reset     (reset),
    .start     (sat_start),
    .step_mode (step_mode),
    .step      (step),
    .bus       (sat_bus.master),
    .halted    (sat_halted),
    .busy      (sat_busy),
    .icount    (sat_icount)
  );

  always #5 clk = ~clk;

  // Reference decode written straight from the instruction table.
  // Layout: {pc_we, s_inc, s_inm, we3, wez, Op}
  function automatic logic [7:0] model(input logic [5:0] op, input logic zv);
    if (op == 6'b111111)    return 8'b0000_0000;
    if (op[5:4] == 2'b00)   return 8'b1111_0000;
    if (op[5:4] == 2'b01)   return {5'b11011, op[3:1]};
    if (op == 6'b100000)    return 8'b1000_0000;
    if (op == 6'b100001)    return {1'b1, ~zv, 6'b0};
    if (op == 6'b100010)    return {1'b1, zv, 6'b0};
    return 8'b1100_0000;
  endfunction

  function automatic logic [7:0] ctrl_vec();
    return {bus.pc_we, bus.s_inc, bus.s_inm, bus.we3, bus.wez, bus.Op};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [5:0] op, input logic zv);
    bus.Opcode = op;
    bus.z      = zv;
    exp_q.push_back(model(op, zv));
  endtask

  task automatic do_reset();
    start = 1'b0; step = 1'b0; step_mode = 1'b0; sat_start = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    exp_icount = '0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({halted, busy, icount, ctrl_vec()} !== 26'b0)
      begin errors++; $display("[TB] FAIL reset_idle got %b want 0", {halted, busy, icount, ctrl_vec()}); end
    repeat (3) tick();
    checks++;
    if ({busy, bus.pc_we, bus.we3} !== 3'b000)
      begin errors++; $display("[TB] FAIL idle_no_start got %b want 000", {busy, bus.pc_we, bus.we3}); end
  endtask

  task automatic test_start_li();
    do_reset();
    applyStimulus(6'b000101, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({busy, bus.pc_we, bus.we3, bus.s_inm} !== 4'b1000)
      begin errors++; $display("[TB] FAIL start_cycle1 got %b want 1000", {busy, bus.pc_we, bus.we3, bus.s_inm}); end
    tick();
    checks++;
    if ({bus.pc_we, bus.we3, bus.s_inm} !== 3'b000)
      begin errors++; $display("[TB] FAIL start_cycle2 got %b want 000", {bus.pc_we, bus.we3, bus.s_inm}); end
    applyStimulus(6'b010100, 1'b0);
    tick();
    exp_v = exp_q.pop_front();
    checks++;
    if (ctrl_vec() !== exp_v)
      begin errors++; $display("[TB] FAIL li_exec got %b want %b", ctrl_vec(), exp_v); end
    tick();
    checks++;
    if (icount !== 16'd1)
      begin errors++; $display("[TB] FAIL li_icount got %0d want 1", icount); end
    tick();
    tick();
    exp_v = exp_q.pop_front();
    checks++;
    if (ctrl_vec() !== exp_v)
      begin errors++; $display("[TB] FAIL alu_exec got %b want %b", ctrl_vec(), exp_v); end
    tick();
    checks++;
    if (icount !== 16'd2)
      begin errors++; $display("[TB] FAIL alu_icount got %0d want 2", icount); end
  endtask

  task automatic test_jumps();
    logic [5:0] ops [6];
    logic       zs  [6];
    ops = '{6'b100001, 6'b100001, 6'b100010, 6'b100010, 6'b100000, 6'b110000};
    zs  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    do_reset();
    applyStimulus(ops[0], zs[0]);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      tick();
      exp_v = exp_q.pop_front();
      exp_icount++;
      checks++;
      if (ctrl_vec() !== exp_v)
        begin errors++; $display("[TB] FAIL jump_exec[%0d] got %b want %b", i, ctrl_vec(), exp_v); end
      if (i < 5) applyStimulus(ops[i+1], zs[i+1]);
      tick();
      checks++;
      if (icount !== exp_icount)
        begin errors++; $display("[TB] FAIL jump_icount[%0d] got %0d want %0d", i, icount, exp_icount); end
    end
  endtask

  task automatic test_step_mode();
    do_reset();
    step_mode = 1'b1;
    applyStimulus(6'b000011, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    exp_v = exp_q.pop_front();
    checks++;
    if (ctrl_vec() !== exp_v)
      begin errors++; $display("[TB] FAIL step_first_exec got %b want %b", ctrl_vec(), exp_v); end
    step = 1'b1;
    applyStimulus(6'b011110, 1'b0);
    tick();
    step = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({busy, bus.pc_we, bus.we3, bus.wez} !== 4'b1000)
        begin errors++; $display("[TB] FAIL pause_hold[%0d] got %b want 1000", i, {busy, bus.pc_we, bus.we3, bus.wez}); end
      tick();
    end
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    tick();
    exp_v = exp_q.pop_front();
    checks++;
    if (ctrl_vec() !== exp_v)
      begin errors++; $display("[TB] FAIL step_exec got %b want %b", ctrl_vec(), exp_v); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({bus.pc_we, bus.we3} !== 2'b00 || icount !== 16'd2)
        begin errors++; $display("[TB] FAIL step_once[%0d] got %b/%0d want 00/2", i, {bus.pc_we, bus.we3}, icount); end
    end
    step_mode = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0)
      begin errors++; $display("[TB] FAIL pause_to_idle got busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    applyStimulus(6'b001001, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    applyStimulus(6'b010110, 1'b0);
    tick();
    exp_v = exp_q.pop_front();
    checks++;
    if (ctrl_vec() !== exp_v)
      begin errors++; $display("[TB] FAIL pre_abort_exec got %b want %b", ctrl_vec(), exp_v); end
    tick();
    tick();
    checks++;
    if (icount !== 16'd1)
      begin errors++; $display("[TB] FAIL pre_abort_icount got %0d want 1", icount); end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({halted, busy, icount, ctrl_vec()} !== 26'b0)
      begin errors++; $display("[TB] FAIL async_reset got %b want 0", {halted, busy, icount, ctrl_vec()}); end
    tick();
    reset = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({busy, bus.we3, bus.wez, icount} !== 19'b0)
        begin errors++; $display("[TB] FAIL abort_quiet[%0d] got %b want 0", i, {busy, bus.we3, bus.wez, icount}); end
    end
  endtask

  task automatic test_halt();
    do_reset();
    applyStimulus(6'b001111, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    applyStimulus(6'b111111, 1'b0);
    tick();
    exp_v = exp_q.pop_front();
    checks++;
    if (ctrl_vec() !== exp_v)
      begin errors++; $display("[TB] FAIL halt_pre_li got %b want %b", ctrl_vec(), exp_v); end
    tick();
    tick();
    tick();
    exp_v = exp_q.pop_front();
    checks++;
    if ({halted, ctrl_vec()} !== {1'b0, exp_v})
      begin errors++; $display("[TB] FAIL hlt_exec got %b want %b", {halted, ctrl_vec()}, {1'b0, exp_v}); end
    tick();
    checks++;
    if ({halted, busy, icount} !== {2'b10, 16'd2})
      begin errors++; $display("[TB] FAIL hlt_state got %b/%0d want 10/2", {halted, busy}, icount); end
    start = 1'b1; step = 1'b1; step_mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if ({halted, ctrl_vec(), icount} !== {1'b1, 8'b0, 16'd2})
        begin errors++; $display("[TB] FAIL hlt_sticky[%0d] got %b want %b", i, {halted, ctrl_vec(), icount}, {1'b1, 8'b0, 16'd2}); end
    end
    start = 1'b0; step = 1'b0; step_mode = 1'b0;
  endtask

  task automatic test_saturation();
    logic [3:0] exp_sat;
    sat_start = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      tick();
      exp_sat = ((n - 1) / 3 > 15) ? 4'd15 : 4'((n - 1) / 3);
      checks++;
      if (sat_icount !== exp_sat)
        begin errors++; $display("[TB] FAIL sat_icount[%0d] got %0d want %0d", n, sat_icount, exp_sat); end
    end
    sat_start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bus.Opcode     = 6'b0;
    bus.z          = 1'b0;
    sat_bus.Opcode = 6'b110000;
    sat_bus.z      = 1'b0;
    test_reset();
    test_start_li();
    test_jumps();
    test_step_mode();
    test_reset_mid();
    test_halt();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
